uart_deserializer: RTL

- Receive stage directly downstream of the `machine` serializer. It consumes the serial `txd` line and rebuilds the 8-bit words that were loaded with `send`/`data`.
- Frame format: idle-high line, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Outputs each recovered byte with a one-cycle valid strobe, plus a framing-error strobe.
- Feeds the capture/check logic in benches and any downstream byte consumer.

---
 rtl/uart_deserializer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_deserializer                                            |
// | Description : Receiver for an idle-high 8N1 serial line. The line passes   |
// |               through a reset-to-1 synchronizer. The recovered byte is     |
// |               presented with a one-cycle valid strobe, and a bad stop bit  |
// |               gives a one-cycle frame_err strobe.                          |
// |               Optional even-parity bit between the data and stop bits is   |
// |               enabled by defining UART_DESERIALIZER_PARITY_EN.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_deserializer #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err
);

    // Mid-bit offset of every sample point, measured from the first low cycle.
    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    // Timer must be able to hold CLKS_PER_BIT itself.
    localparam int TW  = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] MID_T   = TW'(MID);
    localparam logic [TW-1:0] BIT_END = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_DESERIALIZER_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;
    state_t                 state_q;
    logic [TW-1:0]          timer_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic                   frame_err_q;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_one
            // Single-flop synchronizer; idles high out of reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sync_q <= '1;
                else      sync_q <= rxd;
            end
        end else begin : g_sync_multi
            // Multi-flop synchronizer chain; idles high out of reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sync_q <= '1;
                else      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            end
        end
    endgenerate

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_DESERIALIZER_PARITY_EN
    logic par_bad_q;
    logic parity_err_q;
`endif

    // Frame FSM: sample each bit at its centre, emit registered one-cycle strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_DESERIALIZER_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_DESERIALIZER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s) begin
                        // With MID=0 the start bit is already verified here.
                        timer_q   <= T_ONE;
                        bit_idx_q <= '0;
                        state_q   <= (MID == 0) ? S_DATA : S_START;
`ifdef UART_DESERIALIZER_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (timer_q == MID_T) begin
                        timer_q <= T_ONE;
                        state_q <= rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                S_DATA: begin
                    if (timer_q == BIT_END) begin
                        timer_q   <= T_ONE;
                        shift_q   <= {rxd_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_DESERIALIZER_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
`ifdef UART_DESERIALIZER_PARITY_EN
                S_PARITY: begin
                    if (timer_q == BIT_END) begin
                        timer_q   <= T_ONE;
                        // Even parity: line bit must equal XOR of the data bits.
                        par_bad_q <= rxd_s ^ (^shift_q);
                        state_q   <= S_STOP;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (timer_q == BIT_END) begin
                        timer_q <= '0;
                        if (rxd_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`ifdef UART_DESERIALIZER_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                            state_q <= S_IDLE;
                        end else begin
                            // Framing error wins; data keeps the last good byte.
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) must not retrigger a frame.
                    if (rxd_s) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_DESERIALIZER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
